// File: rtl/typing_game_ctrl.sv
// Typing game sequencer: start countdown, elapsed-time clock, error tally and the
// state bus shared with the per-character checker.
//
// state | meaning
// IDLE  | waiting for Enter; session counters held at zero
// READY | 3..1 second countdown, keys ignored
// WORD  | typing, checker reports no outstanding error
// WRONG | typing, checker holds an uncorrected error
// DONE  | passage finished or time expired; results frozen until Enter
module typing_game_ctrl #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter logic [10:0] TEXT_LEN   = 11'd64,
    parameter logic [9:0]  TIME_LIMIT = 10'd600,
    parameter logic [8:0]  KEY_ENTER  = 9'd90
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         been_ready,
    input  logic [10:0]  word_cnt,
    input  logic         correct_n,
    output logic [2:0]   state,
    output logic [1:0]   countdown,
    output logic [9:0]   sec_cnt,
    output logic [7:0]   err_cnt,
    output logic         done
);

    localparam int PW = ($clog2(CLK_FREQ) > 27) ? $clog2(CLK_FREQ) : 27;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_READY = 3'b001,
        S_WORD  = 3'b010,
        S_WRONG = 3'b011,
        S_DONE  = 3'b100
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    cd_q, cd_d;
    logic [9:0]    sec_q, sec_d;
    logic [7:0]    err_q, err_d;
    logic          done_q, done_d;

    logic press, enter, tick, timeout, complete;

    assign press    = been_ready && key_down[last_change];
    assign enter    = press && (last_change == KEY_ENTER);
    assign tick     = (presc_q == PRESC_MAX);
    assign timeout  = tick && (sec_q == TIME_LIMIT - 10'd1);
    assign complete = (word_cnt >= TEXT_LEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            cd_q    <= '0;
            sec_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cd_q    <= cd_d;
            sec_q   <= sec_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        cd_d    = cd_q;
        sec_d   = sec_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                cd_d    = 2'd0;
                sec_d   = '0;
                err_d   = '0;
                if (enter) begin
                    state_d = S_READY;
                    cd_d    = 2'd3;
                end
            end
            S_READY: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    if (cd_q == 2'd1) begin
                        state_d = S_WORD;
                        cd_d    = 2'd0;
                        presc_d = '0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end
            end
            S_WORD, S_WRONG: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && (sec_q < TIME_LIMIT))
                    sec_d = sec_q + 10'd1;
                // Text-length completion is only trusted in WORD; the checker freezes word_cnt in WRONG.
                if (state_q == S_WORD) begin
                    if (complete || timeout) begin
                        state_d = S_DONE;
                    end else if (correct_n) begin
                        state_d = S_WRONG;
                        if (err_q != 8'hFF)
                            err_d = err_q + 8'd1;
                    end
                end else begin
                    if (timeout)
                        state_d = S_DONE;
                    else if (!correct_n)
                        state_d = S_WORD;
                end
            end
            S_DONE: begin
                presc_d = '0;
                if (enter) begin
                    state_d = S_IDLE;
                    sec_d   = '0;
                    err_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                cd_d    = 2'd0;
                sec_d   = '0;
                err_d   = '0;
            end
        endcase
        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

    assign state     = state_q;
    assign countdown = cd_q;
    assign sec_cnt   = sec_q;
    assign err_cnt   = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Directed bench for typing_game_ctrl: a vector table for the main session flow plus
// hand-written sequences for timeout, simultaneous end, error saturation and async reset.
module tb_typing_game_ctrl;

    localparam logic [2:0] IDLE = 3'b000, READY = 3'b001, WORD = 3'b010,
                           WRONG = 3'b011, DONE = 3'b100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] key_down;
    logic [8:0]   last_change;
    logic         been_ready;
    logic [10:0]  word_cnt;
    logic         correct_n;
    logic [2:0]   state;
    logic [1:0]   countdown;
    logic [9:0]   sec_cnt;
    logic [7:0]   err_cnt;
    logic         done;

    logic [511:0] key_down2;
    logic [8:0]   last_change2;
    logic         been_ready2;
    logic [10:0]  word_cnt2;
    logic         correct_n2;
    logic [2:0]   state2;
    logic [1:0]   countdown2;
    logic [9:0]   sec_cnt2;
    logic [7:0]   err_cnt2;
    logic         done2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    typing_game_ctrl #(.CLK_FREQ(10), .TEXT_LEN(11'd4), .TIME_LIMIT(10'd5), .KEY_ENTER(9'd90)) dut (
        .clk(clk), .rst_n(rst_n), .key_down(key_down), .last_change(last_change),
        .been_ready(been_ready), .word_cnt(word_cnt), .correct_n(correct_n),
        .state(state), .countdown(countdown), .sec_cnt(sec_cnt), .err_cnt(err_cnt), .done(done)
    );

    // Long time limit so 300 error entries fit in one session.
    typing_game_ctrl #(.CLK_FREQ(2), .TEXT_LEN(11'd64), .TIME_LIMIT(10'd1000), .KEY_ENTER(9'd90)) dut_sat (
        .clk(clk), .rst_n(rst_n), .key_down(key_down2), .last_change(last_change2),
        .been_ready(been_ready2), .word_cnt(word_cnt2), .correct_n(correct_n2),
        .state(state2), .countdown(countdown2), .sec_cnt(sec_cnt2), .err_cnt(err_cnt2), .done(done2)
    );

    typedef struct {
        logic       br;
        logic       held;
        logic [8:0] code;
        logic [10:0] wc;
        logic       cn;
        int         cyc;
        logic [2:0] st;
        logic [1:0] cd;
        logic [9:0] sec;
        logic [7:0] err;
        logic       dn;
    } vec_t;

    vec_t vec [23];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic br, input logic held, input logic [8:0] code,
                         input logic [10:0] wc, input logic cn);
        key_down    = '0;
        if (held) key_down[code] = 1'b1;
        last_change = code;
        been_ready  = br;
        word_cnt    = wc;
        correct_n   = cn;
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic [1:0] cd,
                             input logic [9:0] sec, input logic [7:0] err, input logic dn);
        chk({tag, ".state"}, state, st);
        chk({tag, ".countdown"}, countdown, cd);
        chk({tag, ".sec_cnt"}, sec_cnt, sec);
        chk({tag, ".err_cnt"}, err_cnt, err);
        chk({tag, ".done"}, done, dn);
    endtask

    task automatic start_game();
        drive(1'b1, 1'b1, 9'd90, 11'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);
        repeat (30) step();
        chk("start.state", state, WORD);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);
        key_down2 = '0; last_change2 = '0; been_ready2 = 1'b0; word_cnt2 = '0; correct_n2 = 1'b0;

        //              br   held code   wc     cn  cyc  st     cd    sec    err   dn
        vec[0]  = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 1,  IDLE,  2'd0, 10'd0, 8'd0, 1'b0};
        vec[1]  = '{1'b1, 1'b1, 9'd28, 11'd0, 1'b0, 1,  IDLE,  2'd0, 10'd0, 8'd0, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 9'd90, 11'd0, 1'b0, 1,  IDLE,  2'd0, 10'd0, 8'd0, 1'b0};
        vec[3]  = '{1'b1, 1'b1, 9'd90, 11'd0, 1'b0, 1,  READY, 2'd3, 10'd0, 8'd0, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 9'd90, 11'd0, 1'b0, 1,  READY, 2'd3, 10'd0, 8'd0, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 8,  READY, 2'd3, 10'd0, 8'd0, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 1,  READY, 2'd2, 10'd0, 8'd0, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 9,  READY, 2'd2, 10'd0, 8'd0, 1'b0};
        vec[8]  = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 1,  READY, 2'd1, 10'd0, 8'd0, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 10, WORD,  2'd0, 10'd0, 8'd0, 1'b0};
        vec[10] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b1, 1,  WRONG, 2'd0, 10'd0, 8'd1, 1'b0};
        vec[11] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b1, 1,  WRONG, 2'd0, 10'd0, 8'd1, 1'b0};
        vec[12] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 1,  WORD,  2'd0, 10'd0, 8'd1, 1'b0};
        vec[13] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 7,  WORD,  2'd0, 10'd1, 8'd1, 1'b0};
        vec[14] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b1, 1,  WRONG, 2'd0, 10'd1, 8'd2, 1'b0};
        vec[15] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b1, 9,  WRONG, 2'd0, 10'd2, 8'd2, 1'b0};
        vec[16] = '{1'b1, 1'b1, 9'd90, 11'd0, 1'b0, 1,  WORD,  2'd0, 10'd2, 8'd2, 1'b0};
        vec[17] = '{1'b0, 1'b0, 9'd0,  11'd3, 1'b0, 1,  WORD,  2'd0, 10'd2, 8'd2, 1'b0};
        vec[18] = '{1'b0, 1'b0, 9'd0,  11'd4, 1'b1, 1,  DONE,  2'd0, 10'd2, 8'd2, 1'b1};
        vec[19] = '{1'b0, 1'b0, 9'd0,  11'd4, 1'b0, 1,  DONE,  2'd0, 10'd2, 8'd2, 1'b0};
        vec[20] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 20, DONE,  2'd0, 10'd2, 8'd2, 1'b0};
        vec[21] = '{1'b1, 1'b1, 9'd90, 11'd0, 1'b0, 1,  IDLE,  2'd0, 10'd0, 8'd0, 1'b0};
        vec[22] = '{1'b0, 1'b0, 9'd0,  11'd0, 1'b0, 1,  IDLE,  2'd0, 10'd0, 8'd0, 1'b0};

        repeat (3) step();
        check_all("reset_held", IDLE, 2'd0, 10'd0, 8'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            for (int c = 0; c < vec[i].cyc; c++) begin
                drive(vec[i].br, vec[i].held, vec[i].code, vec[i].wc, vec[i].cn);
                step();
            end
            check_all($sformatf("vec%0d", i), vec[i].st, vec[i].cd, vec[i].sec, vec[i].err, vec[i].dn);
        end
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);

        // Timeout from WRONG, with a WRONG excursion mid-run that must not pause the clock.
        start_game();
        for (int j = 1; j <= 50; j++) begin
            drive(1'b0, 1'b0, 9'd0, 11'd0, ((j >= 15 && j < 25) || j >= 45));
            step();
            if (j % 10 == 0 && j < 50) chk($sformatf("tmo.sec_j%0d", j), sec_cnt, j / 10);
            if (j == 20) chk("tmo.state_wrong", state, WRONG);
            if (j == 30) chk("tmo.state_word", state, WORD);
            if (j == 49) begin
                chk("tmo.state_j49", state, WRONG);
                chk("tmo.done_j49", done, 1'b0);
            end
        end
        check_all("tmo.end", DONE, 2'd0, 10'd5, 8'd2, 1'b1);
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);
        repeat (5) step();
        check_all("tmo.frozen", DONE, 2'd0, 10'd5, 8'd2, 1'b0);
        drive(1'b1, 1'b1, 9'd90, 11'd0, 1'b0);
        step();
        check_all("tmo.back_idle", IDLE, 2'd0, 10'd0, 8'd0, 1'b0);
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);

        // Completion on the same cycle as the final tick: a single done pulse.
        start_game();
        pulses = 0;
        for (int j = 1; j <= 55; j++) begin
            drive(1'b0, 1'b0, 9'd0, (j >= 50) ? 11'd4 : 11'd0, 1'b0);
            step();
            if (done) pulses++;
            if (j == 50) check_all("sim.end", DONE, 2'd0, 10'd5, 8'd0, 1'b1);
        end
        chk("sim.pulses", pulses, 1);
        drive(1'b1, 1'b1, 9'd90, 11'd0, 1'b0);
        step();
        chk("sim.back_idle", state, IDLE);
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);

        // Error tally saturation on the long-limit instance.
        key_down2[90] = 1'b1; last_change2 = 9'd90; been_ready2 = 1'b1;
        step();
        key_down2 = '0; been_ready2 = 1'b0;
        for (int k = 0; k < 20 && state2 != WORD; k++) step();
        chk("sat.state_word", state2, WORD);
        for (int i = 1; i <= 300; i++) begin
            correct_n2 = 1'b1;
            step();
            if (i == 1) begin
                chk("sat.first_wrong", state2, WRONG);
                chk("sat.first_err", err_cnt2, 1);
            end
            correct_n2 = 1'b0;
            step();
            if (i == 254) chk("sat.err254", err_cnt2, 254);
            if (i == 255) chk("sat.err255", err_cnt2, 255);
        end
        chk("sat.err_final", err_cnt2, 255);
        chk("sat.state_final", state2, WORD);

        // Asynchronous reset between clock edges while in WRONG.
        start_game();
        repeat (12) step();
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b1);
        step();
        check_all("pre_rst", WRONG, 2'd0, 10'd1, 8'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", IDLE, 2'd0, 10'd0, 8'd0, 1'b0);
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 9'd0, 11'd0, 1'b0);
        step();
        check_all("post_rst", IDLE, 2'd0, 10'd0, 8'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
